// File: rtl/mem_responder_if.sv
// Request/response channel between the core (master) and mem_responder (slave).
//   req: i_req_valid / o_req_ready handshake carrying write, addr, wdata, wstrb
//   rsp: o_rsp_valid / i_rsp_ready handshake carrying rdata, err
// Signal names keep the responder-side i_/o_ prefixes so they line up with the
// responder's port list.
interface mem_responder_if #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32
);
  logic                    i_req_valid;
  logic                    o_req_ready;
  logic                    i_req_write;
  logic [ADDR_WIDTH-1:0]   i_req_addr;
  logic [DATA_WIDTH-1:0]   i_req_wdata;
  logic [DATA_WIDTH/8-1:0] i_req_wstrb;
  logic                    o_rsp_valid;
  logic                    i_rsp_ready;
  logic [DATA_WIDTH-1:0]   o_rsp_rdata;
  logic                    o_rsp_err;

  modport master (
    output i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_wstrb, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport slave (
    input  i_req_valid, i_req_write, i_req_addr, i_req_wdata, i_req_wstrb, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side responder for the core's fetch/load/store port.
// One request at a time: word read or byte-strobed write on an internal array,
// answered WAIT_CYCLES+1 cycles after acceptance and held until the core
// takes it.
//   i_clk   : clock, rising edge
//   i_reset : synchronous, active-high reset
//   bus     : mem_responder_if.slave (request and response channels)
module mem_responder #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 1
) (
  input logic            i_clk,
  input logic            i_reset,
  mem_responder_if.slave bus
);
  localparam int MIW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  typedef struct packed {
    logic                    write;
    logic [ADDR_WIDTH-1:0]   addr;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
  } req_t;

  // Contents are not touched by reset; they start at zero from configuration.
  logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

  state_t                  state;
  req_t                    req_q;
  req_t                    acc;
  logic [3:0]              cnt;
  logic                    accept;
  logic                    do_access;
  logic                    acc_err;
  logic [ADDR_WIDTH-3:0]   idx;
  logic [MIW-1:0]          mem_idx;
  logic                    rsp_valid;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    rsp_err;

  assign bus.o_req_ready = (state == IDLE) && !i_reset;
  assign bus.o_rsp_valid = rsp_valid;
  assign bus.o_rsp_rdata = rsp_rdata;
  assign bus.o_rsp_err   = rsp_err;
  assign accept          = bus.i_req_valid && bus.o_req_ready;

  // With zero wait states the access happens on the acceptance edge itself,
  // so it must use the live request rather than the not-yet-latched copy.
  always_comb begin
    acc = req_q;
    if (state == IDLE) begin
      acc.write = bus.i_req_write;
      acc.addr  = bus.i_req_addr;
      acc.wdata = bus.i_req_wdata;
      acc.wstrb = bus.i_req_wstrb;
    end
    idx       = acc.addr[ADDR_WIDTH-1:2];
    mem_idx   = idx[MIW-1:0];
    acc_err   = (acc.addr[1:0] != 2'b00) || (32'(idx) >= 32'(DEPTH_WORDS));
    do_access = ((state == IDLE) && accept && (WAIT_CYCLES == 0)) ||
                ((state == WAIT) && (cnt == 4'd0));
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      req_q     <= '0;
      cnt       <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          req_q <= acc;
          if (WAIT_CYCLES == 0) begin
            state <= RESP;
          end else begin
            cnt   <= 4'(WAIT_CYCLES - 1);
            state <= WAIT;
          end
        end
        WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd0) state <= RESP;
        end
        RESP: if (bus.i_rsp_ready) begin
          state     <= IDLE;
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
        end
        default: state <= IDLE;
      endcase
      if (do_access) begin
        rsp_valid <= 1'b1;
        rsp_err   <= acc_err;
        rsp_rdata <= (!acc_err && !acc.write) ? mem[mem_idx] : '0;
      end
    end
  end

  // Array write kept in its own reset-free block so it maps onto RAM; reset
  // still blocks the commit of a write that was in flight.
  always_ff @(posedge i_clk) begin
    if (do_access && !i_reset && acc.write && !acc_err) begin
      for (int b = 0; b < DATA_WIDTH/8; b++) begin
        if (acc.wstrb[b]) mem[mem_idx][8*b +: 8] <= acc.wdata[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic        req_valid, req_write, rsp_ready;
  logic [13:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  // a: 1 wait state, 1024 words; z: 0 wait states; f: 15 wait states
  mem_responder_if #(.ADDR_WIDTH(14)) if_a ();
  mem_responder_if #(.ADDR_WIDTH(14)) if_z ();
  mem_responder_if #(.ADDR_WIDTH(14)) if_f ();

  mem_responder #(.ADDR_WIDTH(14), .DEPTH_WORDS(1024), .WAIT_CYCLES(1))
    dut_a (.i_clk(clk), .i_reset(rst), .bus(if_a.slave));
  mem_responder #(.ADDR_WIDTH(14), .DEPTH_WORDS(4096), .WAIT_CYCLES(0))
    dut_z (.i_clk(clk), .i_reset(rst), .bus(if_z.slave));
  mem_responder #(.ADDR_WIDTH(14), .DEPTH_WORDS(4096), .WAIT_CYCLES(15))
    dut_f (.i_clk(clk), .i_reset(rst), .bus(if_f.slave));

  assign if_a.i_req_valid = req_valid && (sel == 2'd0);
  assign if_z.i_req_valid = req_valid && (sel == 2'd1);
  assign if_f.i_req_valid = req_valid && (sel == 2'd2);
  assign {if_a.i_req_write, if_a.i_req_addr, if_a.i_req_wdata, if_a.i_req_wstrb, if_a.i_rsp_ready} =
         {req_write, req_addr, req_wdata, req_wstrb, rsp_ready};
  assign {if_z.i_req_write, if_z.i_req_addr, if_z.i_req_wdata, if_z.i_req_wstrb, if_z.i_rsp_ready} =
         {req_write, req_addr, req_wdata, req_wstrb, rsp_ready};
  assign {if_f.i_req_write, if_f.i_req_addr, if_f.i_req_wdata, if_f.i_req_wstrb, if_f.i_rsp_ready} =
         {req_write, req_addr, req_wdata, req_wstrb, rsp_ready};

  always_comb begin
    case (sel)
      2'd1:    {req_ready, rsp_valid, rsp_rdata, rsp_err} = {if_z.o_req_ready, if_z.o_rsp_valid, if_z.o_rsp_rdata, if_z.o_rsp_err};
      2'd2:    {req_ready, rsp_valid, rsp_rdata, rsp_err} = {if_f.o_req_ready, if_f.o_rsp_valid, if_f.o_rsp_rdata, if_f.o_rsp_err};
      default: {req_ready, rsp_valid, rsp_rdata, rsp_err} = {if_a.o_req_ready, if_a.o_rsp_valid, if_a.o_rsp_rdata, if_a.o_rsp_err};
    endcase
  end

  typedef struct {
    string       name;
    logic [1:0]  dut;
    logic        wr;
    logic [13:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [$];

  function automatic vec_t mk(string n, logic [1:0] d, logic w, logic [13:0] a, logic [31:0] wd,
                              logic [3:0] s, int h, logic [31:0] er, logic ee, int el);
    vec_t v;
    v.name = n; v.dut = d; v.wr = w; v.addr = a; v.wdata = wd; v.wstrb = s;
    v.hold = h; v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Full transaction on the selected DUT, all comparisons inline.
  task automatic run(input vec_t v);
    int n;
    logic [31:0] lat;
    sel = v.dut;
    #0;
    n = 0;
    while (!req_ready && n < 50) begin cycle(); n++; end
    check({v.name, "_ready_timeout"}, 64'(n < 50), 64'd1);
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr; req_wdata = v.wdata; req_wstrb = v.wstrb;
    cycle();
    req_valid = 1'b0;
    check({v.name, "_busy"}, 64'(req_ready), 64'd0);
    lat = 1;
    while (!rsp_valid && lat < 40) begin cycle(); lat++; end
    check({v.name, "_latency"}, 64'(lat), 64'(v.exp_lat));
    for (int k = 0; k < v.hold; k++) begin
      cycle();
      check({v.name, "_hold"}, {30'd0, rsp_valid, req_ready, rsp_rdata}, {30'd0, 1'b1, 1'b0, v.exp_rdata});
    end
    check({v.name, "_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
    check({v.name, "_err"}, 64'(rsp_err), 64'(v.exp_err));
    rsp_ready = 1'b1;
    cycle();
    rsp_ready = 1'b0;
    check({v.name, "_rsp_clear"}, {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    check({v.name, "_ready_back"}, 64'(req_ready), 64'd1);
  endtask

  initial begin
    sel = 2'd0; rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = '0; rsp_ready = 1'b0;

    // dut a (latency 2)
    vecs.push_back(mk("rd_0010",      0, 0, 14'h0010, 32'h0,        4'h0, 0, 32'h00000000, 0, 2));
    vecs.push_back(mk("wr_0020_full", 0, 1, 14'h0020, 32'hDEADBEEF, 4'hF, 0, 32'h00000000, 0, 2));
    vecs.push_back(mk("wr_0020_lane0",0, 1, 14'h0020, 32'h000000AA, 4'h1, 0, 32'h00000000, 0, 2));
    vecs.push_back(mk("rd_0020",      0, 0, 14'h0020, 32'h0,        4'h0, 0, 32'hDEADBEAA, 0, 2));
    vecs.push_back(mk("rd_0020_bp",   0, 0, 14'h0020, 32'h0,        4'h0, 5, 32'hDEADBEAA, 0, 2));
    vecs.push_back(mk("rd_misalign",  0, 0, 14'h0022, 32'h0,        4'h0, 0, 32'h00000000, 1, 2));
    vecs.push_back(mk("rd_range",     0, 0, 14'h1000, 32'h0,        4'h0, 0, 32'h00000000, 1, 2));
    vecs.push_back(mk("wr_misalign",  0, 1, 14'h0021, 32'h12345678, 4'hF, 0, 32'h00000000, 1, 2));
    vecs.push_back(mk("rd_0020_kept", 0, 0, 14'h0020, 32'h0,        4'h0, 0, 32'hDEADBEAA, 0, 2));
    vecs.push_back(mk("wr_strb0",     0, 1, 14'h0024, 32'hFFFFFFFF, 4'h0, 0, 32'h00000000, 0, 2));
    vecs.push_back(mk("rd_strb0",     0, 0, 14'h0024, 32'h0,        4'h0, 0, 32'h00000000, 0, 2));
    vecs.push_back(mk("wr_lanes31",   0, 1, 14'h0024, 32'h11223344, 4'hA, 0, 32'h00000000, 0, 2));
    vecs.push_back(mk("rd_lanes31",   0, 0, 14'h0024, 32'h0,        4'h0, 0, 32'h11003300, 0, 2));
    vecs.push_back(mk("rd_last_word", 0, 0, 14'h0FFC, 32'h0,        4'h0, 0, 32'h00000000, 0, 2));
    // dut z (latency 1), back-to-back
    vecs.push_back(mk("z_wr_0040",    1, 1, 14'h0040, 32'hA5A5F00D, 4'hF, 0, 32'h00000000, 0, 1));
    vecs.push_back(mk("z_rd_0040",    1, 0, 14'h0040, 32'h0,        4'h0, 0, 32'hA5A5F00D, 0, 1));
    vecs.push_back(mk("z_rd_0040b",   1, 0, 14'h0040, 32'h0,        4'h0, 0, 32'hA5A5F00D, 0, 1));
    // dut f (latency 16), back-to-back
    vecs.push_back(mk("f_wr_0100",    2, 1, 14'h0100, 32'h0BADC0DE, 4'hC, 0, 32'h00000000, 0, 16));
    vecs.push_back(mk("f_rd_0100",    2, 0, 14'h0100, 32'h0,        4'h0, 0, 32'h0BAD0000, 0, 16));
    vecs.push_back(mk("f_rd_0100b",   2, 0, 14'h0100, 32'h0,        4'h0, 0, 32'h0BAD0000, 0, 16));

    cycle(); cycle();
    check("reset_req_ready", 64'(req_ready), 64'd0);
    check("reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    rst = 1'b0;
    #1;
    check("post_reset_ready", 64'(req_ready), 64'd1);

    foreach (vecs[i]) run(vecs[i]);

    // Reset while in WAIT drops a pending write.
    sel = 2'd0;
    #1;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 14'h0030; req_wdata = 32'h55555555; req_wstrb = 4'hF;
    cycle();
    req_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("wait_reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    check("wait_reset_ready", 64'(req_ready), 64'd1);
    run(mk("rd_0030_after_rst", 0, 0, 14'h0030, 32'h0, 4'h0, 0, 32'h00000000, 0, 2));

    // Reset while in RESP keeps a committed write.
    req_valid = 1'b1; req_write = 1'b1; req_addr = 14'h0034; req_wdata = 32'hCAFEF00D; req_wstrb = 4'hF;
    cycle();
    req_valid = 1'b0;
    cycle();
    check("resp_before_rst", 64'(rsp_valid), 64'd1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    check("resp_reset_rsp", {rsp_valid, rsp_err, rsp_rdata}, 64'd0);
    run(mk("rd_0034_after_rst", 0, 0, 14'h0034, 32'h0, 4'h0, 0, 32'hCAFEF00D, 0, 2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
